// File: rtl/iq_avg_decim.sv
`default_nettype none
// ============================================================================
//  Module   : iq_avg_decim
//  Brief    : Boxcar averager/decimator for paired I/Q samples. It sums 2^n
//             accepted pairs and emits their floor-rounded mean with a
//             one-cycle strobe. Defining IQ_AVG_PEAK_EN adds peak-|x| tracking.
//  Revision : 1.0  initial release
// ============================================================================
module iq_avg_decim #(
    parameter int DWI       = 20,
    parameter int LOG2N_MAX = 6,
    parameter int LW        = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LW-1:0]         navg_log2,
    input  logic                  restart,
    input  logic                  valid_in,
    input  logic signed [DWI-1:0] i_in,
    input  logic signed [DWI-1:0] q_in,
    output logic                  valid_out,
    output logic signed [DWI-1:0] i_out,
    output logic signed [DWI-1:0] q_out,
    output logic signed [DWI-1:0] i_peak,
    output logic signed [DWI-1:0] q_peak
);

    localparam int c_AW = DWI + LOG2N_MAX;
    localparam int c_CW = LOG2N_MAX + 1;
    localparam int c_NW = $clog2(LOG2N_MAX + 2);

    logic [c_NW-1:0]        r_n_l;
    logic [c_NW-1:0]        w_n_new;
    logic [c_NW-1:0]        w_n_eff;
    logic [c_CW-1:0]        r_cnt;
    logic [c_CW-1:0]        w_cnt_eff;
    logic [c_CW-1:0]        w_cnt_last;
    logic signed [c_AW-1:0] r_acc_i;
    logic signed [c_AW-1:0] r_acc_q;
    logic signed [c_AW-1:0] w_sum_i;
    logic signed [c_AW-1:0] w_sum_q;
    logic signed [c_AW-1:0] w_avg_i;
    logic signed [c_AW-1:0] w_avg_q;
    logic                   w_start;
    logic                   w_end;

    // A restart makes the current sample the first of a fresh window,
    // so it picks up the new length and an empty accumulator.
    always_comb begin
        w_n_new    = (int'(navg_log2) > LOG2N_MAX) ? c_NW'(LOG2N_MAX) : c_NW'(navg_log2);
        w_start    = (r_cnt == '0) || restart;
        w_n_eff    = w_start ? w_n_new : r_n_l;
        w_cnt_eff  = restart ? '0 : r_cnt;
        w_cnt_last = (c_CW'(1) << w_n_eff) - c_CW'(1);
        w_end      = valid_in && (w_cnt_eff == w_cnt_last);
        w_sum_i    = (restart ? '0 : r_acc_i) + c_AW'(i_in);
        w_sum_q    = (restart ? '0 : r_acc_q) + c_AW'(q_in);
        w_avg_i    = w_sum_i >>> w_n_eff;
        w_avg_q    = w_sum_q >>> w_n_eff;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_n_l     <= '0;
            r_cnt     <= '0;
            r_acc_i   <= '0;
            r_acc_q   <= '0;
            valid_out <= 1'b0;
            i_out     <= '0;
            q_out     <= '0;
        end else begin
            valid_out <= 1'b0;
            if (valid_in) begin
                if (w_start) begin
                    r_n_l <= w_n_new;
                end
                if (w_end) begin
                    r_acc_i   <= '0;
                    r_acc_q   <= '0;
                    r_cnt     <= '0;
                    i_out     <= w_avg_i[DWI-1:0];
                    q_out     <= w_avg_q[DWI-1:0];
                    valid_out <= 1'b1;
                end else begin
                    r_acc_i <= w_sum_i;
                    r_acc_q <= w_sum_q;
                    r_cnt   <= w_cnt_eff + c_CW'(1);
                end
            end else if (restart) begin
                r_acc_i <= '0;
                r_acc_q <= '0;
                r_cnt   <= '0;
            end
        end
    end

`ifdef IQ_AVG_PEAK_EN
    logic [DWI-1:0] w_abs_i;
    logic [DWI-1:0] w_abs_q;
    logic [DWI-1:0] w_run_i;
    logic [DWI-1:0] w_run_q;
    logic [DWI-1:0] w_base_i;
    logic [DWI-1:0] w_base_q;
    logic [DWI-1:0] r_run_i;
    logic [DWI-1:0] r_run_q;

    // The most-negative code has no positive twin; clip it to full scale.
    function automatic logic [DWI-1:0] f_abs_sat(input logic signed [DWI-1:0] x);
        if (x == {1'b1, {(DWI-1){1'b0}}}) begin
            return {1'b0, {(DWI-1){1'b1}}};
        end else if (x[DWI-1]) begin
            return -x;
        end else begin
            return x;
        end
    endfunction

    always_comb begin
        w_abs_i  = f_abs_sat(i_in);
        w_abs_q  = f_abs_sat(q_in);
        w_base_i = w_start ? '0 : r_run_i;
        w_base_q = w_start ? '0 : r_run_q;
        w_run_i  = (w_base_i > w_abs_i) ? w_base_i : w_abs_i;
        w_run_q  = (w_base_q > w_abs_q) ? w_base_q : w_abs_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_run_i <= '0;
            r_run_q <= '0;
            i_peak  <= '0;
            q_peak  <= '0;
        end else if (valid_in) begin
            if (w_end) begin
                r_run_i <= '0;
                r_run_q <= '0;
                i_peak  <= w_run_i;
                q_peak  <= w_run_q;
            end else begin
                r_run_i <= w_run_i;
                r_run_q <= w_run_q;
            end
        end else if (restart) begin
            r_run_i <= '0;
            r_run_q <= '0;
        end
    end
`else
    assign i_peak = '0;
    assign q_peak = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_iq_avg_decim.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iq_avg_decim
//  Brief    : Self-checking bench for iq_avg_decim: queue-based window model,
//             directed cases with literal expectations, then random traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_iq_avg_decim;

    localparam int c_DWI  = 20;
    localparam int c_NMAX = 6;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [2:0]              navg_log2;
    logic                    restart;
    logic                    valid_in;
    logic signed [c_DWI-1:0] i_in;
    logic signed [c_DWI-1:0] q_in;
    logic                    valid_out;
    logic signed [c_DWI-1:0] i_out;
    logic signed [c_DWI-1:0] q_out;
    logic signed [c_DWI-1:0] i_peak;
    logic signed [c_DWI-1:0] q_peak;

    iq_avg_decim #(.DWI(c_DWI), .LOG2N_MAX(c_NMAX), .LW(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .navg_log2 (navg_log2),
        .restart   (restart),
        .valid_in  (valid_in),
        .i_in      (i_in),
        .q_in      (q_in),
        .valid_out (valid_out),
        .i_out     (i_out),
        .q_out     (q_out),
        .i_peak    (i_peak),
        .q_peak    (q_peak)
    );

    always #5 clk = ~clk;

    int  n_vec    = 0;
    int  n_err    = 0;
    int  n_strobe = 0;
    bit  chk_en   = 1'b0;

`ifdef IQ_AVG_PEAK_EN
    localparam bit c_PEAK = 1'b1;
`else
    localparam bit c_PEAK = 1'b0;
`endif

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    longint m_qi[$];
    longint m_qq[$];
    int     m_nl   = 0;
    longint m_vout = 0;
    longint m_iout = 0;
    longint m_qout = 0;
    longint m_ipk  = 0;
    longint m_qpk  = 0;

    function automatic longint floor_avg(input longint s, input int n);
        longint d;
        longint q;
        d = longint'(1) << n;
        q = s / d;
        if ((s % d) != 0 && s < 0) q = q - 1;
        return q;
    endfunction

    function automatic longint abs_sat(input longint x);
        longint a;
        a = (x < 0) ? -x : x;
        return (a > 524287) ? 524287 : a;
    endfunction

    always @(posedge clk) begin
        longint si;
        longint sq;
        longint pi;
        longint pq;
        int     n;
        m_vout = 0;
        if (rst) begin
            m_qi.delete();
            m_qq.delete();
            m_iout = 0; m_qout = 0; m_ipk = 0; m_qpk = 0;
        end else begin
            if (restart) begin
                m_qi.delete();
                m_qq.delete();
            end
            if (valid_in) begin
                if (m_qi.size() == 0) begin
                    n = int'(navg_log2);
                    m_nl = (n > c_NMAX) ? c_NMAX : n;
                end
                m_qi.push_back(longint'(i_in));
                m_qq.push_back(longint'(q_in));
                if (m_qi.size() == (1 << m_nl)) begin
                    si = 0; sq = 0; pi = 0; pq = 0;
                    foreach (m_qi[k]) begin
                        si += m_qi[k];
                        sq += m_qq[k];
                        if (abs_sat(m_qi[k]) > pi) pi = abs_sat(m_qi[k]);
                        if (abs_sat(m_qq[k]) > pq) pq = abs_sat(m_qq[k]);
                    end
                    m_iout = floor_avg(si, m_nl);
                    m_qout = floor_avg(sq, m_nl);
                    if (c_PEAK) begin
                        m_ipk = pi;
                        m_qpk = pq;
                    end
                    m_vout = 1;
                    m_qi.delete();
                    m_qq.delete();
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            if (valid_out === 1'b1) n_strobe++;
            chk("outputs_known", longint'($isunknown({valid_out, i_out, q_out, i_peak, q_peak})), 0);
            chk("valid_out", longint'(valid_out), m_vout);
            chk("i_out", longint'(i_out), m_iout);
            chk("q_out", longint'(q_out), m_qout);
            chk("i_peak", longint'(i_peak), m_ipk);
            chk("q_peak", longint'(q_peak), m_qpk);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit r, input bit rs, input bit v, input int iv, input int qv);
        rst      = r;
        restart  = rs;
        valid_in = v;
        i_in     = iv[c_DWI-1:0];
        q_in     = qv[c_DWI-1:0];
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    function automatic int rnd_s();
        logic [c_DWI-1:0] t;
        int sel;
        sel = int'($urandom_range(0, 9));
        t   = c_DWI'($urandom);
        if (sel == 0) return -524288;
        if (sel == 1) return 524287;
        return int'($signed(t));
    endfunction

    initial begin
        int s0;
        int iv[4];
        int qv[4];
        navg_log2 = 3'd0;
        drive(1'b1, 1'b0, 1'b0, 0, 0);
        chk_en = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 123, 456);
        chk("rst_valid_out", longint'(valid_out), 0);
        chk("rst_i_out", longint'(i_out), 0);
        chk("rst_q_out", longint'(q_out), 0);
        idle();

        // Case 1: window of 4, floor rounding on Q
        iv = '{4, 8, 12, 16};
        qv = '{-4, -4, -4, -5};
        navg_log2 = 3'd2;
        drive(1'b0, 1'b1, 1'b0, 0, 0);
        s0 = n_strobe;
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, 1'b1, iv[k], qv[k]);
            if (k == 2) chk("c1_no_early_strobe", longint'(valid_out), 0);
        end
        chk("c1_strobe_latency", longint'(valid_out), 1);
        chk("c1_i_out", longint'(i_out), 10);
        chk("c1_q_out", longint'(q_out), -5);
        idle();
        chk("c1_strobe_count", n_strobe - s0, 1);

        // Case 2: pass-through
        navg_log2 = 3'd0;
        s0 = n_strobe;
        drive(1'b0, 1'b0, 1'b1, -7, 3);
        chk("c2_strobe", longint'(valid_out), 1);
        chk("c2_i_out", longint'(i_out), -7);
        drive(1'b0, 1'b0, 1'b1, 9, 3);
        idle();
        chk("c2_strobe_count", n_strobe - s0, 2);

        // Case 3: window of 8 with gaps
        navg_log2 = 3'd3;
        s0 = n_strobe;
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 1'b0, 1'b1, 1, 0);
            if (k < 7) idle();
        end
        chk("c3_strobe", longint'(valid_out), 1);
        chk("c3_i_out", longint'(i_out), 1);
        idle();
        chk("c3_strobe_count", n_strobe - s0, 1);

        // Case 4: restart discards a partial window
        navg_log2 = 3'd2;
        s0 = n_strobe;
        drive(1'b0, 1'b0, 1'b1, 7, 7);
        drive(1'b0, 1'b0, 1'b1, 7, 7);
        drive(1'b0, 1'b1, 1'b0, 0, 0);
        for (int k = 0; k < 4; k++) drive(1'b0, 1'b0, 1'b1, 100, -100);
        idle();
        chk("c4_strobe_count", n_strobe - s0, 1);
        chk("c4_i_out", longint'(i_out), 100);

        // Case 5: mid-window length change applies to the next window
        navg_log2 = 3'd2;
        s0 = n_strobe;
        drive(1'b0, 1'b0, 1'b1, 8, 8);
        navg_log2 = 3'd1;
        for (int k = 0; k < 2; k++) drive(1'b0, 1'b0, 1'b1, 8, 8);
        idle();
        chk("c5_no_strobe_at_3", n_strobe - s0, 0);
        drive(1'b0, 1'b0, 1'b1, 8, 8);
        idle();
        chk("c5_strobe_at_4", n_strobe - s0, 1);
        drive(1'b0, 1'b0, 1'b1, 8, 8);
        drive(1'b0, 1'b0, 1'b1, 8, 8);
        idle();
        chk("c5_short_window", n_strobe - s0, 2);

        // Case 6: peak tracking with most-negative I
        navg_log2 = 3'd1;
        drive(1'b0, 1'b0, 1'b1, -524288, 300);
        drive(1'b0, 1'b0, 1'b1, 5, -2);
        chk("c6_i_out", longint'(i_out), -262142);
        chk("c6_i_peak", longint'(i_peak), c_PEAK ? 524287 : 0);
        chk("c6_q_peak", longint'(q_peak), c_PEAK ? 300 : 0);
        idle();

        // Random traffic, including clamped lengths, restarts and resets
        for (int c = 0; c < 6000; c++) begin
            if ($urandom_range(0, 63) == 0) navg_log2 = 3'($urandom_range(0, 7));
            drive($urandom_range(0, 499) == 0,
                  $urandom_range(0, 199) == 0,
                  $urandom_range(0, 3) != 0,
                  rnd_s(), rnd_s());
        end
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
